timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
Bus-facing configuration and interrupt controller for the SoC tick timer. It holds the CPU-visible timer registers and forwards prescale writes to the timer as a one-cycle write pulse. It tracks elapsed ticks against a programmable compare value and raises a level interrupt, with one-shot or auto-reload operation. It sits between the CPU data bus decode and the timer instance.

Parameters:
PRESCALE_RST, 32'd0, reset value of the PRESCALE register; must equal the timer's reset index; no write pulse is issued at reset.
COMPARE_RST, 32'd100, reset value of the COMPARE register.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
bus_wen  input  1  register write strobe, single cycle
bus_ren  input  1  register read strobe, single cycle
bus_addr  input  3  word index: 0 CTRL, 1 PRESCALE, 2 COMPARE, 3 STATUS, 4 COUNT; 5-7 reserved
bus_wdata  input  32  write data
bus_rdata  output  32  registered read data, valid the cycle after bus_ren
timer_wen  output  1  one-cycle write pulse to the timer
timer_windex  output  32  prescale index to the timer, registered
timer_rdata  input  32  timer tick count, free-running, wraps
irq  output  1  level interrupt = STATUS.IRQ_PENDING & CTRL.IRQ_EN

Behaviour:
- Reset (clk edge with rst=1), applies even mid-operation: CTRL=0, PRESCALE=PRESCALE_RST, COMPARE=COMPARE_RST, IRQ_PENDING=0, base=0, state=IDLE; bus_rdata=0, timer_wen=0, timer_windex=PRESCALE_RST, irq=0.
- CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
- STATUS bits: [0] IRQ_PENDING, write-1-to-clear; [1] RUNNING (state==RUN), read-only.
- COUNT, read-only: elapsed = timer_rdata - base, modulo 2^32; reads 0 unless state is RUN.
- Reserved addresses: reads return 0; writes are ignored.
- Read: bus_rdata updates one cycle after bus_ren and holds until the next read. A read and write to the same register in the same cycle return the pre-write value.
- PRESCALE write: the register updates next cycle. On that same next cycle, timer_windex takes the new value and timer_wen pulses high for exactly one cycle. Back-to-back writes produce back-to-back pulses; the last value wins.
- Compare threshold: the effective compare value is max(COMPARE, 1).
- FSM IDLE: EN=0. A write setting EN=1 moves to ARM.
- FSM ARM (1 cycle): base <= timer_rdata, then move to RUN. The timer resets rdata to a nonzero value, so the controller never assumes a zero start.
- FSM RUN, fire: when elapsed >= effective compare, set IRQ_PENDING.
- FSM RUN, after fire with AUTO_RELOAD=1: base <= base + effective compare (drift-free, mod 2^32); stay in RUN.
- FSM RUN, after fire with AUTO_RELOAD=0: clear EN, move to DONE.
- FSM RUN, EN cleared by write: move to IDLE; IRQ_PENDING is unchanged.
- FSM RUN, PRESCALE or COMPARE write: move to ARM, re-capturing base. Elapsed time restarts.
- FSM DONE: wait; a write setting EN=1 moves to ARM. Writing EN=0 moves to IDLE.
- Wrap-around: timer_rdata wrapping past 2^32 causes no spurious fire, because the subtraction is modulo 2^32.
- Simultaneous events: a new fire in the same cycle as a W1C on IRQ_PENDING leaves IRQ_PENDING=1 (set wins). A CTRL write and a fire in the same cycle: the fire is recorded first, then the CTRL value applies.
- irq is combinational from registered bits only; no glitch paths.

Test Plan:
- Reset: hold rst 3 cycles mid-RUN with IRQ pending -> all registers return to reset values; irq=0, timer_wen=0, bus_rdata=0.
- Prescale forward: write PRESCALE=7 at cycle t -> timer_wen=1 only at t+1, timer_windex=7 from t+1. Read addr1 -> 7.
- One-shot with a real timer at PRESCALE=0 (one tick per 2 clk): write COMPARE=5, then CTRL=0b101.
  - irq rises 10-12 cycles after ARM.
  - CTRL.EN reads 0; STATUS=0b01.
  - Write STATUS=1 -> irq drops next cycle.
- Auto-reload: drive timer_rdata from the bench, starting at 100 and +1 per cycle; COMPARE=4, CTRL=0b111.
  - IRQ_PENDING sets at timer_rdata 104, 108, 112 with no drift.
  - W1C issued in the same cycle as the 108 fire -> IRQ_PENDING stays 1.
- Wrap: bench timer_rdata=0xFFFF_FFFE at ARM, COMPARE=3 -> fire exactly when timer_rdata=0x0000_0001. COUNT reads 2 at timer_rdata=0.
- Restart and edge cases:
  - COMPARE write during RUN -> STATUS.RUNNING is 0 for exactly one cycle (ARM); COUNT restarts from 0.
  - COMPARE=0 -> behaves as COMPARE=1.
  - Read of addr 6 -> 0.

Source files
------------

// File: rtl/timer_ctrl.sv
// Register block for the SoC tick timer. It holds the CPU-visible CTRL, PRESCALE, COMPARE, STATUS and COUNT registers.
// It forwards prescale writes to the timer, and it raises a compare interrupt in one-shot or auto-reload mode.
module timer_ctrl #(
  parameter logic [31:0] PRESCALE_RST = 32'd0,
  parameter logic [31:0] COMPARE_RST  = 32'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        timer_wen,
  output logic [31:0] timer_windex,
  input  logic [31:0] timer_rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_COMPARE  = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_COUNT    = 3'd4;

  state_t      state, state_nxt;
  logic        en, en_nxt, auto_reload, irq_en, irq_pending;
  logic [31:0] prescale, compare, base, base_nxt;
  logic        wr_ctrl, wr_prescale, wr_compare, wr_status;
  logic [31:0] eff_cmp, elapsed, rdata_nxt;
  logic        fire;

  assign wr_ctrl     = bus_wen && (bus_addr == ADDR_CTRL);
  assign wr_prescale = bus_wen && (bus_addr == ADDR_PRESCALE);
  assign wr_compare  = bus_wen && (bus_addr == ADDR_COMPARE);
  assign wr_status   = bus_wen && (bus_addr == ADDR_STATUS);

  // Modulo-2^32 subtraction keeps elapsed correct across timer wrap.
  assign eff_cmp = (compare == 32'd0) ? 32'd1 : compare;
  assign elapsed = timer_rdata - base;
  assign fire    = (state == RUN) && (elapsed >= eff_cmp);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    en_nxt    = en;
    base_nxt  = base;
    case (state)
      IDLE: if (wr_ctrl && bus_wdata[0]) state_nxt = ARM;
      ARM: begin
        base_nxt  = timer_rdata;
        state_nxt = RUN;
        if (wr_ctrl && !bus_wdata[0])       state_nxt = IDLE;
        else if (wr_prescale || wr_compare) state_nxt = ARM;
      end
      RUN: begin
        if (fire) begin
          if (auto_reload) base_nxt = base + eff_cmp;
          else begin
            en_nxt    = 1'b0;
            state_nxt = DONE;
          end
        end
        // The fire outcome is settled first, then a same-cycle CTRL write overrides it.
        if (wr_ctrl) begin
          if (!bus_wdata[0])           state_nxt = IDLE;
          else if (state_nxt == DONE)  state_nxt = ARM;
        end else if (wr_prescale || wr_compare) begin
          state_nxt = ARM;
        end
      end
      DONE:    if (wr_ctrl) state_nxt = bus_wdata[0] ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (wr_ctrl) en_nxt = bus_wdata[0];
  end

  always_comb begin
    rdata_nxt = '0;
    case (bus_addr)
      ADDR_CTRL:     rdata_nxt = {29'd0, irq_en, auto_reload, en};
      ADDR_PRESCALE: rdata_nxt = prescale;
      ADDR_COMPARE:  rdata_nxt = compare;
      ADDR_STATUS:   rdata_nxt = {30'd0, (state == RUN), irq_pending};
      ADDR_COUNT:    rdata_nxt = (state == RUN) ? elapsed : '0;
      default:       rdata_nxt = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      prescale    <= PRESCALE_RST;
      compare     <= COMPARE_RST;
      base        <= '0;
      bus_rdata   <= '0;
      timer_wen   <= 1'b0;
    end else begin
      state     <= state_nxt;
      en        <= en_nxt;
      base      <= base_nxt;
      timer_wen <= wr_prescale;
      if (wr_ctrl) begin
        auto_reload <= bus_wdata[1];
        irq_en      <= bus_wdata[2];
      end
      if (wr_prescale) prescale <= bus_wdata;
      if (wr_compare)  compare  <= bus_wdata;
      // When a new fire and a W1C land together, the set wins.
      if (fire)                          irq_pending <= 1'b1;
      else if (wr_status && bus_wdata[0]) irq_pending <= 1'b0;
      if (bus_ren) bus_rdata <= rdata_nxt;
    end
  end

  assign timer_windex = prescale;
  assign irq          = irq_pending & irq_en;

endmodule
